// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter that drains a first-word-fall-through FIFO, with its own 16x baud tick generator.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.

module uart_tx_fifo_drain #(
  parameter int DATA_WIDTH = 8,
  parameter int SB_TICK    = 16,
  parameter int DVSR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DVSR_WIDTH-1:0] dvsr,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_r_data,
  output logic                  fifo_rd,
  output logic                  tx,
  output logic                  tx_busy,
  output logic                  tx_done_tick
);

  // The tick counter also times the stop bit, so it widens when SB_TICK exceeds 16.
  localparam int TICK_W = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [TICK_W-1:0] BIT_LAST  = TICK_W'(15);
  localparam logic [TICK_W-1:0] STOP_LAST = TICK_W'(SB_TICK - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_TX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } state_t;

  state_t                  r_state;
  logic [DVSR_WIDTH-1:0]   r_baud_cnt;
  logic [TICK_W-1:0]       r_tick_cnt;
  logic [BIT_W-1:0]        r_bit_cnt;
  logic [DATA_WIDTH-1:0]   r_shift;
  logic                    r_tx;
  logic                    r_done;

  state_t                  w_state_next;
  logic [TICK_W-1:0]       w_tick_cnt_next;
  logic [BIT_W-1:0]        w_bit_cnt_next;
  logic [DATA_WIDTH-1:0]   w_shift_next;
  logic                    w_tx_next;
  logic                    w_done_next;
  logic                    w_pop;
  logic                    w_s_tick;

`ifdef UART_TX_PARITY_EN
  logic                    r_parity;
  logic                    w_parity_next;
`endif

  assign w_s_tick = (r_state != ST_IDLE) && (r_baud_cnt == dvsr);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves a latch.
    w_state_next    = r_state;
    w_tick_cnt_next = r_tick_cnt;
    w_bit_cnt_next  = r_bit_cnt;
    w_shift_next    = r_shift;
    w_tx_next       = 1'b1;
    w_done_next     = 1'b0;
    w_pop           = 1'b0;
`ifdef UART_TX_PARITY_EN
    w_parity_next   = r_parity;
`endif
    unique case (r_state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          w_pop           = 1'b1;
          w_shift_next    = fifo_r_data;
          w_tick_cnt_next = '0;
          w_bit_cnt_next  = '0;
`ifdef UART_TX_PARITY_EN
          w_parity_next   = ^fifo_r_data;
`endif
          w_state_next    = ST_START;
        end
      end
      ST_START: begin
        w_tx_next = 1'b0;
        if (w_s_tick) begin
          if (r_tick_cnt == BIT_LAST) begin
            w_tick_cnt_next = '0;
            w_bit_cnt_next  = '0;
            w_state_next    = ST_DATA;
          end else begin
            w_tick_cnt_next = r_tick_cnt + TICK_W'(1);
          end
        end
      end
      ST_DATA: begin
        w_tx_next = r_shift[0];
        if (w_s_tick) begin
          if (r_tick_cnt == BIT_LAST) begin
            w_tick_cnt_next = '0;
            w_shift_next    = r_shift >> 1;
            if (r_bit_cnt == DATA_LAST) begin
`ifdef UART_TX_PARITY_EN
              w_state_next = ST_PARITY;
`else
              w_state_next = ST_STOP;
`endif
            end else begin
              w_bit_cnt_next = r_bit_cnt + BIT_W'(1);
            end
          end else begin
            w_tick_cnt_next = r_tick_cnt + TICK_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        w_tx_next = r_parity;
        if (w_s_tick) begin
          if (r_tick_cnt == BIT_LAST) begin
            w_tick_cnt_next = '0;
            w_state_next    = ST_STOP;
          end else begin
            w_tick_cnt_next = r_tick_cnt + TICK_W'(1);
          end
        end
      end
`endif
      ST_STOP: begin
        if (w_s_tick) begin
          if (r_tick_cnt == STOP_LAST) begin
            w_tick_cnt_next = '0;
            w_done_next     = 1'b1;
            w_state_next    = ST_IDLE;
          end else begin
            w_tick_cnt_next = r_tick_cnt + TICK_W'(1);
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_baud_cnt <= '0;
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
      r_done     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_next;
      r_tick_cnt <= w_tick_cnt_next;
      r_bit_cnt  <= w_bit_cnt_next;
      r_shift    <= w_shift_next;
      r_tx       <= w_tx_next;
      r_done     <= w_done_next;
`ifdef UART_TX_PARITY_EN
      r_parity   <= w_parity_next;
`endif
      // Baud counter rests at zero in IDLE so the start bit is always a full 16 ticks.
      if (r_state == ST_IDLE || r_baud_cnt == dvsr)
        r_baud_cnt <= '0;
      else
        r_baud_cnt <= r_baud_cnt + DVSR_WIDTH'(1);
    end
  end

  assign fifo_rd      = w_pop & ~reset;
  assign tx           = r_tx;
  assign tx_busy      = (r_state != ST_IDLE);
  assign tx_done_tick = r_done;

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Self-checking bench for uart_tx_fifo_drain: a queue-backed FIFO feeds the DUT and a frame-level
// model (bit list times bit length) predicts tx, tx_busy, tx_done_tick and fifo_rd cycle by cycle.

module tb_uart_tx_fifo_drain;

`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] dvsr;
  logic [10:0] dvsr2;
  logic        fifo_empty, fifo_rd, tx, tx_busy, tx_done_tick;
  logic [7:0]  fifo_r_data;
  logic        fifo_empty2, fifo_rd2, tx2, tx_busy2, tx_done_tick2;
  logic [7:0]  fifo_r_data2;

  logic        sel;
  logic        m_tx, m_rd, m_busy, m_done;

  logic [7:0]  fifo_q[$];
  logic [7:0]  fifo2_q[$];
  logic        pend, pend2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_fifo_drain #(.DATA_WIDTH(8), .SB_TICK(16), .DVSR_WIDTH(11)) dut (
    .clk(clk), .reset(reset), .dvsr(dvsr), .fifo_empty(fifo_empty), .fifo_r_data(fifo_r_data),
    .fifo_rd(fifo_rd), .tx(tx), .tx_busy(tx_busy), .tx_done_tick(tx_done_tick)
  );

  uart_tx_fifo_drain #(.DATA_WIDTH(8), .SB_TICK(32), .DVSR_WIDTH(11)) dut_sb32 (
    .clk(clk), .reset(reset), .dvsr(dvsr2), .fifo_empty(fifo_empty2), .fifo_r_data(fifo_r_data2),
    .fifo_rd(fifo_rd2), .tx(tx2), .tx_busy(tx_busy2), .tx_done_tick(tx_done_tick2)
  );

  assign m_tx   = sel ? tx2           : tx;
  assign m_rd   = sel ? fifo_rd2      : fifo_rd;
  assign m_busy = sel ? tx_busy2      : tx_busy;
  assign m_done = sel ? tx_done_tick2 : tx_done_tick;

  // FIFO model: a pop seen before an edge removes the head just after that edge.
  initial begin
    fifo_empty   = 1'b1;
    fifo_r_data  = '0;
    fifo_empty2  = 1'b1;
    fifo_r_data2 = '0;
    pend  = 1'b0;
    pend2 = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (pend && fifo_q.size() > 0) void'(fifo_q.pop_front());
      if (pend2 && fifo2_q.size() > 0) void'(fifo2_q.pop_front());
      fifo_empty   = (fifo_q.size() == 0);
      fifo_r_data  = fifo_empty ? 8'h00 : fifo_q[0];
      fifo_empty2  = (fifo2_q.size() == 0);
      fifo_r_data2 = fifo_empty2 ? 8'h00 : fifo2_q[0];
      @(negedge clk);
      pend  = fifo_rd && !reset;
      pend2 = fifo_rd2 && !reset;
    end
  end

  task automatic wait_rd(input int max_cycles, input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (m_rd === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s pop: fifo_rd stayed 0 for %0d cycles, required 1", name, max_cycles);
    end
  endtask

  // Called at the negedge where fifo_rd is high; returns at the negedge where tx_done_tick is expected.
  task automatic check_frame(input logic [7:0] w, input int dv, input int sbt, input string name);
    bit   bits[$];
    int   ones, bl, nb, f, pos;
    int   tx_bad, done_bad, busy_bad, rd_bad, tx_at, done_at;
    logic tx_act, tx_exp, etx;
    ones = 0;
    bits.push_back(1'b0);
    for (int b = 0; b < 8; b++) begin
      bits.push_back(w[b]);
      if (w[b]) ones++;
    end
    if (PAR != 0) bits.push_back(bit'(ones % 2));
    bl = 16 * (dv + 1);
    nb = bits.size();
    f  = nb * bl + sbt * (dv + 1);
    tx_bad = 0; done_bad = 0; busy_bad = 0; rd_bad = 0; tx_at = -1; done_at = -1;
    tx_act = 1'b0; tx_exp = 1'b0;
    for (int i = 1; i <= f + 1; i++) begin
      @(negedge clk);
      pos = i - 2;
      if (pos < 0 || pos / bl >= nb) etx = 1'b1;
      else etx = bits[pos / bl];
      if (m_tx !== etx) begin
        if (tx_bad == 0) begin
          tx_at = i; tx_act = m_tx; tx_exp = etx;
        end
        tx_bad++;
      end
      if (m_done !== (i == f + 1)) begin
        if (done_bad == 0) done_at = i;
        done_bad++;
      end
      if (m_busy !== (i <= f)) busy_bad++;
      if (i <= f && m_rd !== 1'b0) rd_bad++;
    end
    checks += 4;
    if (tx_bad != 0) begin
      errors++;
      $display("FAIL %s tx: %0d cycles wrong, first at cycle %0d after pop got %b expected %b",
               name, tx_bad, tx_at, tx_act, tx_exp);
    end
    if (done_bad != 0) begin
      errors++;
      $display("FAIL %s done: %0d cycles wrong, first at cycle %0d, expected single pulse at cycle %0d",
               name, done_bad, done_at, f + 1);
    end
    if (busy_bad != 0) begin
      errors++;
      $display("FAIL %s busy: %0d cycles wrong, expected high for cycles 1..%0d", name, busy_bad, f);
    end
    if (rd_bad != 0) begin
      errors++;
      $display("FAIL %s rd: %0d extra fifo_rd cycles inside frame, expected 0", name, rd_bad);
    end
  endtask

  task automatic check_quiet(input int n, input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (m_rd !== 1'b0 || m_tx !== 1'b1 || m_busy !== 1'b0 || m_done !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s idle: %0d cycles not idle (rd=%b tx=%b busy=%b), required rd=0 tx=1 busy=0",
               name, bad, m_rd, m_tx, m_busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    dvsr  = '0;
    dvsr2 = '0;
    sel   = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({tx, tx_busy, tx_done_tick, fifo_rd} !== 4'b1000) begin
      errors++;
      $display("FAIL reset state: {tx,busy,done,rd}=%b, required 1000", {tx, tx_busy, tx_done_tick, fifo_rd});
    end
    @(posedge clk);
    #2 reset = 1'b0;
  endtask

  task automatic test_empty_idle();
    check_quiet(200, "empty_fifo");
  endtask

  task automatic test_single_55();
    bit ok;
    @(negedge clk);
    dvsr = 11'd0;
    fifo_q.push_back(8'h55);
    wait_rd(5, "single_55", ok);
    if (ok) check_frame(8'h55, 0, 16, "single_55");
    check_quiet(30, "after_55");
  endtask

  task automatic test_back_to_back();
    bit ok;
    @(negedge clk);
    dvsr = 11'd3;
    fifo_q.push_back(8'hA3);
    fifo_q.push_back(8'h0F);
    wait_rd(5, "b2b_first", ok);
    if (ok) begin
      check_frame(8'hA3, 3, 16, "b2b_A3");
      checks++;
      if (m_rd !== 1'b1) begin
        errors++;
        $display("FAIL b2b gap: fifo_rd=%b at frame length + 1 cycles, required 1", m_rd);
      end
      check_frame(8'h0F, 3, 16, "b2b_0F");
    end
    check_quiet(40, "after_b2b");
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    int tgt;
    @(negedge clk);
    dvsr = 11'd0;
    fifo_q.push_back(8'hFF);
    fifo_q.push_back(8'h3C);
    wait_rd(5, "rst_mid", ok);
    if (ok) begin
      tgt = 2 + 16 * 4 + 8;
      for (int i = 1; i <= tgt; i++) @(negedge clk);
      checks++;
      if (tx !== 1'b1 || tx_busy !== 1'b1) begin
        errors++;
        $display("FAIL rst_mid bit3: tx=%b busy=%b, required tx=1 busy=1", tx, tx_busy);
      end
      @(posedge clk);
      #2 reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({tx, tx_busy, tx_done_tick, fifo_rd} !== 4'b1000) begin
        errors++;
        $display("FAIL rst_mid after: {tx,busy,done,rd}=%b, required 1000", {tx, tx_busy, tx_done_tick, fifo_rd});
      end
      @(posedge clk);
      #2 reset = 1'b0;
      wait_rd(5, "rst_mid_next", ok);
      if (ok) check_frame(8'h3C, 0, 16, "rst_mid_3C");
    end
    check_quiet(20, "after_rst_mid");
  endtask

  task automatic test_parity_words();
    bit ok;
    @(negedge clk);
    dvsr = 11'd1;
    fifo_q.push_back(8'h07);
    wait_rd(5, "word_07", ok);
    if (ok) check_frame(8'h07, 1, 16, "word_07");
    @(negedge clk);
    fifo_q.push_back(8'h03);
    wait_rd(5, "word_03", ok);
    if (ok) check_frame(8'h03, 1, 16, "word_03");
  endtask

  task automatic test_random();
    bit         ok;
    int         dv;
    logic [7:0] w;
    for (int k = 0; k < 6; k++) begin
      repeat ($urandom_range(1, 4)) @(negedge clk);
      dv   = $urandom_range(0, 2);
      w    = 8'($urandom);
      dvsr = 11'(dv);
      fifo_q.push_back(w);
      wait_rd(5, "random", ok);
      if (ok) check_frame(w, dv, 16, $sformatf("random%0d_%02h", k, w));
    end
  endtask

  task automatic test_stop32();
    bit ok;
    @(negedge clk);
    sel = 1'b1;
    fifo2_q.push_back(8'h00);
    wait_rd(5, "stop32", ok);
    if (ok) check_frame(8'h00, 0, 32, "stop32");
    check_quiet(10, "after_stop32");
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_empty_idle();
    test_single_55();
    test_back_to_back();
    test_reset_mid_frame();
    test_parity_words();
    test_random();
    test_stop32();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "time limit");
  end

endmodule
